// File: rtl/pixel_pkg.sv
// Shared pixel-stream definitions used by the packer on the transmit side and by
// frame_line_capture on the receive side.
//  - Default grid geometry and the counter widths derived from it.
//  - Byte-lane packing of 24-bit RGB pixels: 4 pixels are carried in 3 32-bit words.
//      w0 = {p1[7:0],  p0}
//      w1 = {p2[15:0], p1[23:8]}
//      w2 = {p3,       p2[23:16]}
//  - Word-phase and capture FSM state encodings.
package pixel_pkg;

  localparam int unsigned XSizeDefault = 1280;
  localparam int unsigned YSizeDefault = 720;
  localparam int unsigned XWidthDefault = $clog2(XSizeDefault);
  localparam int unsigned YWidthDefault = $clog2(YSizeDefault);

  localparam int unsigned WordBits = 32;
  localparam int unsigned PixelBits = 24;
  // Carried bytes: one byte after w0, two bytes after w1.
  localparam int unsigned ResidueBits = 16;
  localparam int unsigned PixelsPerGroup = 4;
  localparam int unsigned WordsPerGroup = 3;
  // Red channel byte within a pixel {r,g,b}.
  localparam int unsigned RedMsb = 23;
  localparam int unsigned RedLsb = 16;

  typedef enum logic [1:0] {
    PhW0,
    PhW1,
    PhW2
  } pack_phase_e;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StWrite,
    StResync
  } cap_state_e;

  function automatic int unsigned words_per_line(input int unsigned x_size);
    return (x_size * WordsPerGroup) / PixelsPerGroup;
  endfunction

endpackage

// File: rtl/rgb_unpacker.sv
// Unpacks the 3-word / 4-pixel RGB stream back into pixels.
//  clk_i, rst_i    clock and synchronous active-high reset
//  word_i          packed input word
//  accept_i        word is consumed this cycle
//  sof_i           treat this word as w0 regardless of current phase
//  last_i          line end marker travelling with the word
//  pix_a_o/_valid  first pixel completed by this word (every accepted word)
//  pix_b_o/_valid  second pixel, only completed by w2
//  eol_o           accepted word carries the line end
module rgb_unpacker
  import pixel_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WordBits-1:0]  word_i,
  input  logic                 accept_i,
  input  logic                 sof_i,
  input  logic                 last_i,
  output logic [PixelBits-1:0] pix_a_o,
  output logic                 pix_a_valid_o,
  output logic [PixelBits-1:0] pix_b_o,
  output logic                 pix_b_valid_o,
  output logic                 eol_o
);

  pack_phase_e phase_q, phase_d, phase_eff;
  logic [ResidueBits-1:0] residue_q, residue_d;

  always_comb begin
    phase_eff     = sof_i ? PhW0 : phase_q;
    phase_d       = phase_q;
    residue_d     = residue_q;
    pix_a_o       = word_i[23:0];
    pix_b_o       = word_i[31:8];
    pix_a_valid_o = accept_i;
    pix_b_valid_o = 1'b0;
    eol_o         = accept_i & last_i;
    unique case (phase_eff)
      PhW0: begin
        pix_a_o   = word_i[23:0];
        residue_d = {8'h00, word_i[31:24]};
        phase_d   = PhW1;
      end
      PhW1: begin
        pix_a_o   = {word_i[15:0], residue_q[7:0]};
        residue_d = word_i[31:16];
        phase_d   = PhW2;
      end
      PhW2: begin
        pix_a_o       = {word_i[7:0], residue_q};
        pix_b_valid_o = accept_i;
        phase_d       = PhW0;
      end
      default: phase_d = PhW0;
    endcase
    if (!accept_i) begin
      phase_d   = phase_q;
      residue_d = residue_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q   <= PhW0;
      residue_q <= '0;
    end else begin
      phase_q   <= phase_d;
      residue_q <= residue_d;
    end
  end

endmodule

// File: rtl/frame_line_capture.sv
// AXI4-Stream video sink that thresholds packed RGB pixels into 1-bit cells and writes
// each completed grid line into a line BRAM port at its row address.
//  in_stream_aclk / periph_reset   clock, synchronous active-high reset
//  capture_en                      arm capture (looked at only while idle / at frame end)
//  in_stream_t*                    AXI4-Stream slave; tuser = SOF, tlast = EOL
//  line_addr/line_data/line_we     BRAM write port; line_data bit [X_SIZE-1-x] = pixel x
//  frame_done                      pulses with the write of the last row
//  err_sof/err_eol/err_keep        sticky error flags, cleared by err_clr or reset
module frame_line_capture
  import pixel_pkg::*;
#(
  parameter int unsigned X_SIZE  = XSizeDefault,
  parameter int unsigned Y_SIZE  = YSizeDefault,
  parameter logic [7:0]  THRESH  = 8'h40,
  parameter int unsigned X_WIDTH = $clog2(X_SIZE),
  parameter int unsigned Y_WIDTH = $clog2(Y_SIZE)
) (
  input  logic               in_stream_aclk,
  input  logic               periph_reset,
  input  logic               capture_en,
  input  logic [31:0]        in_stream_tdata,
  input  logic [3:0]         in_stream_tkeep,
  input  logic               in_stream_tlast,
  input  logic               in_stream_tuser,
  input  logic               in_stream_tvalid,
  output logic               in_stream_tready,
  output logic [Y_WIDTH-1:0] line_addr,
  output logic [X_SIZE-1:0]  line_data,
  output logic               line_we,
  output logic               frame_done,
  output logic               err_sof,
  output logic               err_eol,
  output logic               err_keep,
  input  logic               err_clr
);

  localparam int unsigned Wpl = words_per_line(X_SIZE);
  localparam logic [X_WIDTH-1:0] LastWord = X_WIDTH'(Wpl - 1);
  localparam logic [Y_WIDTH-1:0] LastRow = Y_WIDTH'(Y_SIZE - 1);

  cap_state_e         state_q, state_d;
  logic [X_WIDTH-1:0] word_q, word_d, px_q, px_d;
  logic [Y_WIDTH-1:0] row_q, row_d;
  logic [X_SIZE-1:0]  line_q, line_d, line_next;
  logic [Y_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [X_SIZE-1:0]  line_data_q, line_data_d;
  logic               line_we_q, line_we_d;
  logic               frame_done_q, frame_done_d;
  logic               err_sof_q, err_eol_q, err_keep_q;
  logic               set_sof, set_eol;

  logic               hs, row0_word0, take, restart, sof_err;
  logic [X_WIDTH-1:0] w_eff, px_eff, px_b;
  logic [Y_WIDTH-1:0] row_eff;

  logic [PixelBits-1:0] pix_a, pix_b;
  logic                 pix_a_valid, pix_b_valid, unpk_eol;
  logic                 alive_a, alive_b;

  always_comb begin
    case (state_q)
      StIdle:  in_stream_tready = capture_en;
      StWrite: in_stream_tready = 1'b0;
      default: in_stream_tready = 1'b1;
    endcase
    if (periph_reset) in_stream_tready = 1'b0;
  end

  assign hs         = in_stream_tvalid & in_stream_tready;
  assign row0_word0 = (row_q == '0) && (word_q == '0);

  // Words are only taken into the line when they can belong to one: a new frame (and
  // resync) needs tuser, and row 0 word 0 in capture also waits for tuser.
  always_comb begin
    case (state_q)
      StIdle, StResync: take = hs & in_stream_tuser;
      StCapture:        take = hs & (in_stream_tuser | ~row0_word0);
      default:          take = 1'b0;
    endcase
  end

  assign restart = take & in_stream_tuser;
  assign sof_err = restart & (state_q == StCapture) & ~row0_word0;
  assign w_eff   = restart ? '0 : word_q;
  assign px_eff  = restart ? '0 : px_q;
  assign row_eff = restart ? '0 : row_q;
  assign px_b    = px_eff + 1'b1;

  rgb_unpacker u_unpacker (
    .clk_i         (in_stream_aclk),
    .rst_i         (periph_reset),
    .word_i        (in_stream_tdata),
    .accept_i      (take),
    .sof_i         (restart),
    .last_i        (in_stream_tlast),
    .pix_a_o       (pix_a),
    .pix_a_valid_o (pix_a_valid),
    .pix_b_o       (pix_b),
    .pix_b_valid_o (pix_b_valid),
    .eol_o         (unpk_eol)
  );

  assign alive_a = pix_a[RedMsb:RedLsb] >= THRESH;
  assign alive_b = pix_b[RedMsb:RedLsb] >= THRESH;

  // Line register with this word's cells merged in; word 0 starts from a clean line.
  always_comb begin
    line_next = (w_eff == '0) ? '0 : line_q;
    for (int x = 0; x < X_SIZE; x++) begin
      if (pix_a_valid && (px_eff == X_WIDTH'(x))) line_next[X_SIZE-1-x] = alive_a;
      if (pix_b_valid && (px_b == X_WIDTH'(x))) line_next[X_SIZE-1-x] = alive_b;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    px_d         = px_q;
    row_d        = row_q;
    line_d       = line_q;
    line_addr_d  = line_addr_q;
    line_data_d  = line_data_q;
    line_we_d    = 1'b0;
    frame_done_d = 1'b0;
    set_sof      = 1'b0;
    set_eol      = 1'b0;
    unique case (state_q)
      StIdle, StCapture, StResync: begin
        if (take) begin
          set_sof = sof_err;
          line_d  = line_next;
          row_d   = row_eff;
          if ((w_eff == LastWord) && unpk_eol) begin
            state_d      = StWrite;
            line_we_d    = 1'b1;
            line_addr_d  = row_eff;
            line_data_d  = line_next;
            frame_done_d = (row_eff == LastRow);
          end else if ((w_eff == LastWord) || unpk_eol) begin
            // Line length wrong either way; wait for the next SOF.
            set_eol = 1'b1;
            state_d = StResync;
            word_d  = '0;
            px_d    = '0;
            row_d   = '0;
          end else begin
            state_d = StCapture;
            word_d  = w_eff + 1'b1;
            px_d    = pix_b_valid ? px_eff + X_WIDTH'(2) : px_eff + X_WIDTH'(1);
          end
        end
      end
      StWrite: begin
        word_d = '0;
        px_d   = '0;
        if (row_q == LastRow) begin
          row_d   = '0;
          state_d = capture_en ? StCapture : StIdle;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = StCapture;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      state_q      <= StIdle;
      word_q       <= '0;
      px_q         <= '0;
      row_q        <= '0;
      line_q       <= '0;
      line_addr_q  <= '0;
      line_data_q  <= '0;
      line_we_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eol_q    <= 1'b0;
      err_keep_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      px_q         <= px_d;
      row_q        <= row_d;
      line_q       <= line_d;
      line_addr_q  <= line_addr_d;
      line_data_q  <= line_data_d;
      line_we_q    <= line_we_d;
      frame_done_q <= frame_done_d;
      // A new error in the clearing cycle wins.
      err_sof_q    <= (err_sof_q & ~err_clr) | set_sof;
      err_eol_q    <= (err_eol_q & ~err_clr) | set_eol;
      err_keep_q   <= (err_keep_q & ~err_clr) | (hs & (in_stream_tkeep != 4'hF));
    end
  end

  assign line_addr  = line_addr_q;
  assign line_data  = line_data_q;
  assign line_we    = line_we_q;
  assign frame_done = frame_done_q;
  assign err_sof    = err_sof_q;
  assign err_eol    = err_eol_q;
  assign err_keep   = err_keep_q;

endmodule

// File: tb/tb_frame_line_capture.sv
module tb_frame_line_capture;

  localparam int unsigned XS = 8;
  localparam int unsigned YS = 2;
  localparam logic [7:0] TH = 8'h40;
  localparam int WPL = 6;

  logic        clk = 1'b0;
  logic        rst, cap_en, err_clr;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic [0:0]  line_addr;
  logic [7:0]  line_data;
  logic        line_we, frame_done, err_sof, err_eol, err_keep;

  always #5 clk = ~clk;

  frame_line_capture #(
    .X_SIZE (XS),
    .Y_SIZE (YS),
    .THRESH (TH)
  ) dut (
    .in_stream_aclk   (clk),
    .periph_reset     (rst),
    .capture_en       (cap_en),
    .in_stream_tdata  (tdata),
    .in_stream_tkeep  (tkeep),
    .in_stream_tlast  (tlast),
    .in_stream_tuser  (tuser),
    .in_stream_tvalid (tvalid),
    .in_stream_tready (tready),
    .line_addr        (line_addr),
    .line_data        (line_data),
    .line_we          (line_we),
    .frame_done       (frame_done),
    .err_sof          (err_sof),
    .err_eol          (err_eol),
    .err_keep         (err_keep),
    .err_clr          (err_clr)
  );

  typedef struct packed {
    logic [0:0] addr;
    logic [7:0] data;
    logic       fd;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          gap_max = 0;
  logic        chk_rdy = 1'b0;
  logic [23:0] pix[XS];
  logic [31:0] words[WPL];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: pixel x becomes bit [XS-1-x], alive when red >= threshold.
  function automatic logic [7:0] model_line();
    logic [7:0] l;
    for (int x = 0; x < XS; x++) l[XS-1-x] = (pix[x][23:16] >= TH);
    return l;
  endfunction

  function automatic void pack_words();
    for (int g = 0; g < XS / 4; g++) begin
      words[3*g]   = {pix[4*g+1][7:0], pix[4*g]};
      words[3*g+1] = {pix[4*g+2][15:0], pix[4*g+1][23:8]};
      words[3*g+2] = {pix[4*g+3], pix[4*g+2][23:16]};
    end
  endfunction

  function automatic void rand_pix();
    for (int x = 0; x < XS; x++) begin
      if ($urandom_range(0, 1) == 1) pix[x] = {8'($urandom_range(8'h3C, 8'h44)), 16'($urandom)};
      else pix[x] = 24'($urandom);
    end
  endfunction

  function automatic void push_exp(input int row);
    wr_t e;
    e.addr = 1'(row);
    e.data = model_line();
    e.fd   = (row == YS - 1);
    exp_q.push_back(e);
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l, input logic u,
                           input logic [3:0] k, input logic clr);
    int n;
    tvalid = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
    tdata = d; tlast = l; tuser = u; tkeep = k; err_clr = clr; tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (tready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 100) begin
        n_fail++;
        $display("FAIL handshake_timeout: tready stuck at %0b", tready);
        $fatal(1, "handshake timeout");
      end
    end
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tkeep = 4'hF; err_clr = 1'b0;
  endtask

  task automatic send_line(input int user_at, input int last_at, input int stop_at,
                           input int keep_bad_at, input int clr_at);
    pack_words();
    for (int i = 0; i <= stop_at; i++)
      send_word(words[i], i == last_at, i == user_at, (i == keep_bad_at) ? 4'h0 : 4'hF,
                i == clr_at);
  endtask

  task automatic clean_frame();
    for (int r = 0; r < YS; r++) begin
      rand_pix();
      push_exp(r);
      send_line((r == 0) ? 0 : -1, WPL - 1, WPL - 1, -1, -1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending_writes", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  // Scoreboard monitor: compare every BRAM write against the queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (line_we) begin
        check("tready_during_write", tready, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected", line_addr, line_data);
        end else begin
          e = exp_q.pop_front();
          check("line_addr", line_addr, e.addr);
          check("line_data", line_data, e.data);
          check("frame_done", frame_done, e.fd);
        end
      end else begin
        if (frame_done) check("frame_done_without_write", frame_done, 0);
        if (chk_rdy && cap_en) check("tready_open", tready, 1);
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cap_en = 1'b0; err_clr = 1'b0;
    tdata = '0; tkeep = 4'hF; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tready", tready, 0);
    check("reset_line_we", line_we, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_line_addr", line_addr, 0);
    check("reset_line_data", line_data, 0);
    check("reset_errors", {err_sof, err_eol, err_keep}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap_en = 1'b1;
    chk_rdy = 1'b1;

    // 1: alternating red/black -> 8'hAA on both rows
    for (int r = 0; r < YS; r++) begin
      for (int x = 0; x < XS; x++) pix[x] = (x % 2 == 0) ? 24'hFF0000 : 24'h000000;
      push_exp(r);
      send_line((r == 0) ? 0 : -1, WPL - 1, WPL - 1, -1, -1);
    end
    drain();
    check("t1_errors", {err_sof, err_eol, err_keep}, 0);

    // 2: threshold edges
    pix[0] = 24'h3F0000; pix[1] = 24'h400000; pix[2] = 24'h00FFFF; pix[3] = 24'h410000;
    pix[4] = 24'h000000; pix[5] = 24'hFFFFFF; pix[6] = 24'h3FFFFF; pix[7] = 24'h400000;
    push_exp(0);
    send_line(0, WPL - 1, WPL - 1, -1, -1);
    rand_pix();
    push_exp(1);
    send_line(-1, WPL - 1, WPL - 1, -1, -1);
    drain();

    // 3: early tlast, then missing tlast, each followed by a clean frame
    rand_pix();
    send_line(0, 3, 3, -1, -1);
    drain();
    check("t3_err_eol_early", err_eol, 1);
    clean_frame();
    drain();
    pulse_clr();
    check("t3_err_eol_cleared", err_eol, 0);
    rand_pix();
    send_line(0, -1, WPL - 1, -1, -1);
    drain();
    check("t3_err_eol_missing", err_eol, 1);
    clean_frame();
    drain();
    pulse_clr();

    // 4: tuser in row 1 word 2 restarts at row 0
    rand_pix();
    push_exp(0);
    send_line(0, WPL - 1, WPL - 1, -1, -1);
    rand_pix();
    send_line(-1, -1, 1, -1, -1);
    rand_pix();
    push_exp(0);
    send_line(0, WPL - 1, WPL - 1, -1, -1);
    rand_pix();
    push_exp(1);
    send_line(-1, WPL - 1, WPL - 1, -1, -1);
    drain();
    check("t4_err_sof", err_sof, 1);
    check("t4_err_eol", err_eol, 0);

    // 7: err_clr coincident with a bad tkeep; the word is still consumed
    rand_pix();
    push_exp(0);
    send_line(0, WPL - 1, WPL - 1, 1, 1);
    rand_pix();
    push_exp(1);
    send_line(-1, WPL - 1, WPL - 1, -1, -1);
    drain();
    check("t7_err_keep_set", err_keep, 1);
    check("t7_err_sof_cleared", err_sof, 0);

    // 5: random gaps, random pixels
    gap_max = 3;
    for (int f = 0; f < 5; f++) clean_frame();
    drain();
    gap_max = 0;
    check("t5_errors", {err_sof, err_eol, err_keep}, 3'b001);

    // 6: reset in the middle of a line
    rand_pix();
    send_line(0, -1, 2, -1, -1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_tready", tready, 0);
    check("rst_mid_line_we", line_we, 0);
    check("rst_mid_frame_done", frame_done, 0);
    check("rst_mid_line_addr", line_addr, 0);
    check("rst_mid_line_data", line_data, 0);
    check("rst_mid_errors", {err_sof, err_eol, err_keep}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clean_frame();
    drain();
    check("t6_errors", {err_sof, err_eol, err_keep}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
